// File: rtl/student_logic_pkg.sv
// student_logic_pkg: opcodes and default width shared by the student logic
// arbiter and its logic unit.
package student_logic_pkg;
  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;
  localparam int WIDTH_DEFAULT = 16;
endpackage

// File: rtl/student_logic16.sv
// student_logic16: combinational NOT/AND/OR/XOR unit built only from the
// NAND-based student gates, followed by a 4:1 select on op.
//   op : opcode (00 NOT a, 01 AND, 10 OR, 11 XOR)
//   a,b: operands          y : result
// Gate cells:
//   student_nand1 : single-bit NAND, the only primitive.
//   student_not16/and16/or16/xor16 : per-bit arrays of NAND compositions.
module student_nand1 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = !(a && b);
endmodule

module student_not16 #(parameter int W = 16) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  student_nand1 u_n [W-1:0] (.a(a), .b(a), .y(y));
endmodule

module student_and16 #(parameter int W = 16) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic [W-1:0] n;
  student_nand1 u_n [W-1:0] (.a(a), .b(b), .y(n));
  student_not16 #(.W(W)) u_inv (.a(n), .y(y));
endmodule

module student_or16 #(parameter int W = 16) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic [W-1:0] na, nb;
  student_not16 #(.W(W)) u_ia (.a(a), .y(na));
  student_not16 #(.W(W)) u_ib (.a(b), .y(nb));
  student_nand1 u_n [W-1:0] (.a(na), .b(nb), .y(y));
endmodule

module student_xor16 #(parameter int W = 16) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  // classic four-NAND xor
  logic [W-1:0] n, na, nb;
  student_nand1 u_n  [W-1:0] (.a(a),  .b(b),  .y(n));
  student_nand1 u_na [W-1:0] (.a(a),  .b(n),  .y(na));
  student_nand1 u_nb [W-1:0] (.a(b),  .b(n),  .y(nb));
  student_nand1 u_o  [W-1:0] (.a(na), .b(nb), .y(y));
endmodule

module student_logic16
  import student_logic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] y_not, y_and, y_or, y_xor;

  student_not16 #(.W(WIDTH)) u_not (.a(a), .y(y_not));
  student_and16 #(.W(WIDTH)) u_and (.a(a), .b(b), .y(y_and));
  student_or16  #(.W(WIDTH)) u_or  (.a(a), .b(b), .y(y_or));
  student_xor16 #(.W(WIDTH)) u_xor (.a(a), .b(b), .y(y_xor));

  always_comb begin
    y = y_not;
    case (op)
      OP_NOT:  y = y_not;
      OP_AND:  y = y_and;
      OP_OR:   y = y_or;
      OP_XOR:  y = y_xor;
      default: y = y_not;
    endcase
  end
endmodule

// File: rtl/student_logic_arbiter.sv
// student_logic_arbiter: round-robin share of one student_logic16 between two
// requesters, with a one-entry registered result stage (1-cycle latency,
// one op per cycle sustained when the consumer is always ready).
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   reqN_valid/ready/op/a/b (N=0,1) : request channels (valid/ready)
//   res_valid/ready/id/data         : result channel (valid/ready)
// Optional: define STUDENT_ARB_STATS_EN to add grant_cnt0/grant_cnt1,
//   16-bit saturating acceptance counters per requester.
module student_logic_arbiter
  import student_logic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_data
`ifdef STUDENT_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);
  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  req_t             req0, req1, sel;
  logic             full, last_grant, grant, can_accept, acc;
  logic [WIDTH-1:0] y;

  assign req0 = '{op: req0_op, a: req0_a, b: req0_b};
  assign req1 = '{op: req1_op, a: req1_a, b: req1_b};

  // rst_n gates the window so no ready is offered while reset is held
  assign can_accept = rst_n && (!full || res_ready);

  // contested: take the side that did not win last; otherwise whoever is valid
  assign grant = (req0_valid && req1_valid) ? !last_grant : req1_valid;
  assign acc   = can_accept && (req0_valid || req1_valid);

  assign req0_ready = can_accept && req0_valid && !grant;
  assign req1_ready = can_accept && req1_valid && grant;

  assign sel = grant ? req1 : req0;

  student_logic16 #(.WIDTH(WIDTH)) u_logic (
    .op (sel.op),
    .a  (sel.a),
    .b  (sel.b),
    .y  (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= 1'b0;
      last_grant <= 1'b1;
      res_id     <= 1'b0;
      res_data   <= '0;
    end else if (acc) begin
      full       <= 1'b1;
      last_grant <= grant;
      res_id     <= grant;
      res_data   <= y;
    end else if (res_ready) begin
      full       <= 1'b0;
    end
  end

  assign res_valid = full;

`ifdef STUDENT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (acc) begin
      if (!grant && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (grant  && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: doc/student_logic_arbiter.md
Name: student_logic_arbiter

Overview:
- Shares one 16-bit bitwise logic unit (NOT/AND/OR/XOR) between two requesters.
- Round-robin arbitration; valid/ready on both the request and result sides.
- One-entry registered result stage, so an accepted request's result appears the next cycle.
- Sits between the 16-bit gate bank and its clients (e.g. a future ALU sequencer and a test driver).

Parameters:
- WIDTH, 16, operand/result width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_op  input  2  requester 0 opcode
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- res_valid  output  1  result register holds a result
- res_ready  input  1  consumer takes the result this cycle
- res_id  output  1  index of the requester that owns the result
- res_data  output  WIDTH  result value

Behaviour:
- Opcodes: 00 = NOT a (b ignored), 01 = a AND b, 10 = a OR b, 11 = a XOR b.
- Logic is built from the team's NAND-based student gates; no built-in bitwise operators.
- Internal state:
  - full flag (mirrored on res_valid)
  - last_grant (1 bit)
  - res_id and res_data registers
- Reset (async, rst_n low):
  - res_valid=0, res_id=0, res_data=0, last_grant=1, so requester 0 wins the first contest.
  - Any held result is discarded.
  - Ready outputs are 0 while in reset.
- Acceptance window: can_accept = !res_valid || res_ready.
- Grant, combinational:
  - Only one valid requester: grant it.
  - Both valid: grant the one not equal to last_grant.
  - reqN_ready = can_accept && reqN_valid && grant==N; at most one ready is high per cycle.
- On acceptance (rising edge):
  - res_data <= op(a,b); res_id <= grant; res_valid <= 1; last_grant <= grant.
  - Latency is 1 cycle.
- Result drained with no acceptance in the same cycle: res_valid <= 0.
- Drain and acceptance in the same cycle: the register is reloaded and res_valid stays 1. Full throughput of one op per cycle is sustained.
- Result held with res_ready=0:
  - res_valid, res_id and res_data stay stable.
  - No grant is issued and last_grant is unchanged.
- Requesters hold valid and payload stable until ready.
  - Dropping valid before ready is legal; the request simply vanishes.
- last_grant changes only on an actual acceptance. An idle cycle does not rotate priority.
- With both valid and the consumer always ready, grants alternate 0,1,0,1…

Optional Feature:
- Macro STUDENT_ARB_STATS_EN.
- Defined:
  - Adds ports grant_cnt0 and grant_cnt1, each output, 16 bits.
  - Each counts acceptances for its requester, reset to 0, saturating at 16'hFFFF (no wrap).
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package student_logic_pkg holds:
  - opcode localparams OP_NOT=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_XOR=2'b11
  - WIDTH_DEFAULT=16
- Sub-module student_logic16:
  - combinational, inputs op, a, b; output y
  - built from student_not16/and16/or16/xor16 plus a 4:1 select
  - one instance, fed by the granted requester's payload.

Test Plan:
- Reset, then req0 only with op=01, a=16'hF0F0, b=16'hFF00, res_ready=1:
  - req0_ready high in cycle 0.
  - Next cycle res_valid=1, res_id=0, res_data=16'hF000.
- Both requesters valid for 4 cycles (req0 NOT 16'h00FF, req1 XOR 16'hAAAA^16'h5555), res_ready=1:
  - Grants in order 0,1,0,1.
  - Results 16'hFF00, 16'hFFFF, 16'hFF00, 16'hFFFF, one per cycle.
- Backpressure: hold res_ready=0 for 3 cycles after an accept:
  - res_data is stable and both readies stay 0.
  - On release, drain and a new accept happen in the same cycle; res_valid never drops.
- Only req1 valid for 3 cycles, then both valid:
  - last_grant=1, so the next contest grants requester 0.
- Assert rst_n low while res_valid=1 and res_ready=0:
  - res_valid drops immediately (asynchronous).
  - After release, requester 0 wins the first contest.
- With STUDENT_ARB_STATS_EN, 70000 req0 accepts:
  - grant_cnt0 = 16'hFFFF (saturated).
  - grant_cnt1 = 0.
